bram_frame_sequencer: RTL and testbench



---
 rtl/bram_frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_bram_frame_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_frame_sequencer.sv
// bram_frame_sequencer
//   Single-port controller for the pixel frame BRAM. On start it reads the
//   frame from address 0 to NUM_PIXELS-1 and streams the pixels downstream
//   over valid/ready. A credit-limited FIFO absorbs the BRAM read latency.
//   One write requester shares the BRAM port, and contested cycles are
//   resolved round-robin.
// Ports
//   clka, rsta_n            : clock, asynchronous active-low reset
//   start / busy / done     : scan request, scan in progress, end-of-frame pulse
//   wr_req/wr_addr/wr_data  : write request (held until wr_gnt)
//   wr_gnt                  : write performed this cycle (combinational)
//   m_valid/m_ready/m_data/m_addr/m_last : pixel output stream
//   ena/wea/addra/dina/douta: BRAM port
module bram_frame_sequencer #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned NUM_PIXELS = 2501,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t                           r_state, w_state_nxt;
  logic                             r_done, w_done_nxt;
  logic                             r_run;
  logic                             r_rr_wr;
  logic [ADDR_W-1:0]                r_rd_ptr;
  logic [RD_LAT-1:0]                r_tag_v;
  logic [RD_LAT-1:0][ADDR_W-1:0]    r_tag_addr;
  logic [RD_LAT-1:0]                r_tag_last;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] r_f_data;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] r_f_addr;
  logic [FIFO_DEPTH-1:0]            r_f_last;
  logic [PTR_W-1:0]                 r_wp, r_rp;
  logic [CNT_W-1:0]                 r_cnt;

  logic [CRD_W-1:0] w_inflight, w_used;
  logic             w_rd_elig, w_wr_req, w_contest, w_wr_win, w_rd_win;
  logic             w_push, w_pop;

  // Credits: reads already in the tag pipe count against FIFO space so the
  // FIFO can never overflow, regardless of downstream stalls.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++)
      w_inflight = w_inflight + CRD_W'(r_tag_v[i]);
    w_used    = CRD_W'(r_cnt) + w_inflight;
    w_rd_elig = (r_state == S_SCAN) && (w_used < CRD_W'(FIFO_DEPTH));
    // r_run keeps the write port quiet while reset is asserted
    w_wr_req  = wr_req & r_run;
    w_contest = w_rd_elig & w_wr_req;
    w_wr_win  = w_wr_req & (~w_rd_elig | r_rr_wr);
    w_rd_win  = w_rd_elig & ~w_wr_win;
  end

  always_comb begin
    wr_gnt = w_wr_win;
    ena    = w_wr_win | w_rd_win;
    wea    = w_wr_win;
    addra  = '0;
    dina   = '0;
    if (w_wr_win) begin
      addra = wr_addr;
      dina  = wr_data;
    end else if (w_rd_win) begin
      addra = r_rd_ptr;
    end
  end

  assign m_valid = (r_cnt != '0);
  assign m_data  = r_f_data[r_rp];
  assign m_addr  = r_f_addr[r_rp];
  assign m_last  = r_f_last[r_rp];
  assign w_pop   = m_valid & m_ready;
  assign w_push  = r_tag_v[RD_LAT-1];
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_rd_win && (r_rd_ptr == LAST_ADDR)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && m_last) begin
                 w_state_nxt = S_IDLE;
                 w_done_nxt  = 1'b1;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_run      <= 1'b0;
      r_rr_wr    <= 1'b0;
      r_rd_ptr   <= '0;
      r_tag_v    <= '0;
      r_tag_addr <= '0;
      r_tag_last <= '0;
      r_f_data   <= '0;
      r_f_addr   <= '0;
      r_f_last   <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_run   <= 1'b1;
      if (w_contest) r_rr_wr <= ~r_rr_wr;

      if ((r_state == S_IDLE) && start) r_rd_ptr <= '0;
      else if (w_rd_win)                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);

      // Tag pipe lines up with douta: the last stage marks the cycle the
      // BRAM data for that read is on douta.
      r_tag_v[0]    <= w_rd_win;
      r_tag_addr[0] <= r_rd_ptr;
      r_tag_last[0] <= (r_rd_ptr == LAST_ADDR);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_addr[i] <= r_tag_addr[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end

      if (w_push) begin
        r_f_data[r_wp] <= douta;
        r_f_addr[r_wp] <= r_tag_addr[RD_LAT-1];
        r_f_last[r_wp] <= r_tag_last[RD_LAT-1];
        r_wp <= (r_wp == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wp + PTR_W'(1);
      end
      if (w_pop)
        r_rp <= (r_rp == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rp + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_frame_sequencer.sv
module tb_bram_frame_sequencer;

  localparam int NPIX = 2501;
  localparam int AW   = 12;
  localparam int RDL  = 1;
  localparam int FD   = 4;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic            rsta_n, start, wr_req, m_ready;
  logic [AW-1:0]   wr_addr;
  logic [23:0]     wr_data;
  logic            busy, done, wr_gnt, m_valid, m_last, ena, wea;
  logic [23:0]     m_data, dina, douta;
  logic [AW-1:0]   m_addr, addra;

  logic            start2, m_ready2, wr_req2;
  logic [3:0]      wr_addr2, m_addr2, addra2;
  logic [23:0]     wr_data2, m_data2, dina2, douta2, d2a;
  logic            busy2, done2, wr_gnt2, m_valid2, m_last2, ena2, wea2;

  bram_frame_sequencer #(.ADDR_W(AW), .DATA_W(24), .NUM_PIXELS(NPIX), .RD_LAT(RDL), .FIFO_DEPTH(FD)) dut (
    .clka(clka), .rsta_n(rsta_n), .start(start), .busy(busy), .done(done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_last(m_last),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta));

  bram_frame_sequencer #(.ADDR_W(4), .DATA_W(24), .NUM_PIXELS(1), .RD_LAT(2), .FIFO_DEPTH(3)) dut2 (
    .clka(clka), .rsta_n(rsta_n), .start(start2), .busy(busy2), .done(done2),
    .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_gnt(wr_gnt2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_addr(m_addr2), .m_last(m_last2),
    .ena(ena2), .wea(wea2), .addra(addra2), .dina(dina2), .douta(douta2));

  // Frame BRAMs (environment)
  logic [23:0] mem  [0:(1<<AW)-1];
  logic [23:0] mem2 [0:15];
  always @(posedge clka) if (ena) begin
    if (wea) mem[addra] <= dina; else douta <= mem[addra];
  end
  always @(posedge clka) begin
    if (ena2) begin
      if (wea2) mem2[addra2] <= dina2; else d2a <= mem2[addra2];
    end
    douta2 <= d2a;
  end

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: shadow frame memory plus scan/credit bookkeeping
  typedef struct { int addr; logic [23:0] data; bit last; int vis; } beat_t;
  beat_t       sb[$];
  logic [23:0] ref_mem [0:(1<<AW)-1];
  bit  mdl_en = 0, m_busy, m_scan, m_rr_wr, pend_done, last_gw;
  int  m_next_rd, m_issued, m_popped, wgnt_cnt, done_seen;
  logic [23:0] seen5, seen100;

  always @(negedge clka) begin
    bit ed, rd_el, gw, gr;
    if (!mdl_en) begin
      sb.delete();
      m_busy = 0; m_scan = 0; m_rr_wr = 0; pend_done = 0; last_gw = 0;
      m_next_rd = 0; m_issued = 0; m_popped = 0;
    end else begin
      ed = pend_done;
      if (pend_done) begin m_busy = 0; pend_done = 0; end
      check("busy", busy, m_busy);
      check("done", done, ed);
      rd_el = m_scan && ((m_issued - m_popped) < FD);
      gw = wr_req && (!rd_el || m_rr_wr);
      gr = rd_el && !gw;
      check("wr_gnt", wr_gnt, gw);
      check("ena", ena, gw | gr);
      check("wea", wea, gw);
      if (gw) begin
        check("addra_wr", addra, wr_addr);
        check("dina_wr", dina, wr_data);
      end else if (gr) begin
        check("addra_rd", addra, m_next_rd);
        check("dina_rd", dina, 0);
      end else begin
        check("addra_idle", addra, 0);
        check("dina_idle", dina, 0);
      end
      last_gw = gw;
      if (gw) wgnt_cnt++;
      if (rd_el && wr_req) m_rr_wr = !m_rr_wr;
      if (gw) ref_mem[wr_addr] = wr_data;
      if (gr) begin
        sb.push_back('{m_next_rd, ref_mem[m_next_rd], (m_next_rd == NPIX-1), cyc + RDL + 1});
        m_issued++;
        m_next_rd++;
        if (m_next_rd == NPIX) m_scan = 0;
      end
      if (start && !m_busy) begin
        m_busy = 1; m_scan = 1; m_next_rd = 0; m_issued = 0; m_popped = 0;
      end
    end
  end

  // Monitor: compares the output stream against the scoreboard
  bit          prev_stall;
  logic [23:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic        prev_last;
  always @(negedge clka) begin
    beat_t e;
    #2;
    if (!mdl_en) prev_stall = 0;
    else begin
      if (done) done_seen++;
      check("m_valid", m_valid, (sb.size() > 0) && (cyc >= sb[0].vis));
      if (prev_stall) begin
        check("hold_data", m_data, prev_data);
        check("hold_addr", m_addr, prev_addr);
        check("hold_last", m_last, prev_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data; prev_addr = m_addr; prev_last = m_last;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check("extra_beat", 1, 0);
        else begin
          e = sb.pop_front();
          check("m_addr", m_addr, e.addr);
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
          if (e.addr == 5) seen5 = m_data;
          if (e.addr == 100) seen100 = m_data;
          m_popped++;
          if (e.last) pend_done = 1;
        end
      end
    end
  end

  // Input driver: ready and write-request patterns selected by mode
  int rdy_mode = 0, wr_mode = 0;
  bit w3_done = 0;
  always @(posedge clka) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      2: m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    case (wr_mode)
      1: begin wr_req = 1; wr_addr = 100; wr_data = 24'hFF0000; end
      2: if (!wr_req || last_gw) begin
           if ($urandom_range(0, 3) == 0) begin
             wr_req = 1;
             wr_addr = AW'($urandom_range(0, NPIX-1));
             wr_data = 24'($urandom);
           end else wr_req = 0;
         end
      3: if (!w3_done) begin
           if (last_gw) begin wr_req = 0; w3_done = 1; end
           else begin wr_req = 1; wr_addr = 5; wr_data = 24'h00FF00; end
         end
      default: begin wr_req = 0; w3_done = 0; end
    endcase
  end

  task automatic pulse_start();
    @(posedge clka); #1 start = 1;
    @(posedge clka); #1 start = 0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 20000; k++) begin
      @(negedge clka); #1;
      if (done) break;
    end
    check({nm, "_timeout"}, (k < 20000), 1);
    @(negedge clka); #3;
    check({nm, "_done_once"}, done_seen, 1);
    check({nm, "_beats"}, m_popped, NPIX);
    check({nm, "_busy_after"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"}, busy, 0);     check({nm, "_done"}, done, 0);
    check({nm, "_m_valid"}, m_valid, 0); check({nm, "_m_last"}, m_last, 0);
    check({nm, "_m_data"}, m_data, 0); check({nm, "_m_addr"}, m_addr, 0);
    check({nm, "_wr_gnt"}, wr_gnt, 0); check({nm, "_ena"}, ena, 0);
    check({nm, "_wea"}, wea, 0);       check({nm, "_addra"}, addra, 0);
    check({nm, "_dina"}, dina, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s, vcyc, rd2;
    rsta_n = 0; start = 0; start2 = 0; m_ready2 = 1; wr_req2 = 0; wr_addr2 = 0; wr_data2 = 0;
    wr_req = 0; wr_addr = 0; wr_data = 0; m_ready = 1;
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = 24'(i); ref_mem[i] = 24'(i); end
    for (int i = 0; i < 16; i++) mem2[i] = 24'h123400 | 24'(i);
    #3;
    check_reset_outputs("por");
    repeat (3) @(posedge clka);
    #3 rsta_n = 1;
    @(posedge clka); #1 mdl_en = 1;

    // write in IDLE, then a clean full-rate scan
    wr_mode = 3;
    for (k = 0; k < 20; k++) begin @(negedge clka); #3; if (w3_done) break; end
    check("idle_write_granted", w3_done, 1);
    wr_mode = 0;
    done_seen = 0; seen5 = 0;
    pulse_start();
    wait_done("scan1");
    check("pixel5_written", seen5, 24'h00FF00);

    // backpressure: toggling ready, then a full stall, then random ready + writes
    done_seen = 0;
    rdy_mode = 1;
    pulse_start();
    repeat (100) @(posedge clka);
    pulse_start();                       // ignored while busy
    repeat (200) @(posedge clka);
    rdy_mode = 2;
    repeat (10) @(posedge clka);
    for (int i = 0; i < 10; i++) begin
      @(negedge clka); #1;
      check("stall_ena", ena, 0);
      check("stall_valid", m_valid, 1);
    end
    rdy_mode = 3; wr_mode = 2;
    wait_done("scan2");
    rdy_mode = 0; wr_mode = 0;

    // contention: write to address 100 held throughout the scan
    done_seen = 0; seen100 = 0; wgnt_cnt = 0;
    pulse_start();
    wr_mode = 1;
    wait_done("scan3");
    wr_mode = 0;
    check("contend_wr_gnt_seen", (wgnt_cnt > 1000), 1);
    check("pixel100_written", seen100, 24'hFF0000);

    // async reset in the middle of a scan
    rdy_mode = 3; wr_mode = 2;
    pulse_start();
    for (k = 0; k < 5000; k++) begin @(negedge clka); #3; if (m_popped >= 300) break; end
    check("reach_300_timeout", (k < 5000), 1);
    @(posedge clka); #3;
    mdl_en = 0; rsta_n = 0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clka);
    #3 rsta_n = 1; wr_mode = 0;
    repeat (2) @(posedge clka);
    #1 mdl_en = 1;
    @(negedge clka); #1;
    check("post_rst_done_quiet", done, 0);
    done_seen = 0; wr_mode = 2;
    pulse_start();
    wait_done("scan4");
    rdy_mode = 0; wr_mode = 0;

    // second instance: RD_LAT=2, one-pixel frame
    rd2 = 0; vcyc = -1;
    @(posedge clka); #1 start2 = 1; s = cyc;
    for (k = 0; k < 20; k++) begin
      @(negedge clka);
      if (ena2 && !wea2) rd2++;
      if (m_valid2) begin vcyc = cyc; break; end
      @(posedge clka); #1 start2 = 0;
    end
    check("lat2_valid_cycle", vcyc - s, 4);
    check("lat2_m_addr", m_addr2, 0);
    check("lat2_m_data", m_data2, 24'h123400);
    check("lat2_m_last", m_last2, 1);
    check("lat2_reads", rd2, 1);
    @(negedge clka);
    check("lat2_done", done2, 1);
    check("lat2_busy", busy2, 0);
    @(negedge clka);
    check("lat2_done_pulse", done2, 0);
    check("lat2_valid_clear", m_valid2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
